axi4_lite_master: RTL and testbench

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

---
 rtl/axi4_lite_master.sv | 228 ++++++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response handshake.
// Define AXI_MASTER_TIMEOUT_EN to add the sticky response watchdog and its timeout output.
module axi4_lite_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESETN,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
`ifdef AXI_MASTER_TIMEOUT_EN
    output logic        timeout,
`endif
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp} state_e;

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_write_q, rsp_write_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_resp_q, rsp_resp_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic [31:0] araddr_q, araddr_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        accept;

    // cmd_ready_q is only ever set while idle, so it alone qualifies acceptance.
    assign accept = cmd_valid && cmd_ready_q;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;

        unique case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = StWrReq;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = StRdReq;
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWrReq: begin
                // AW and W channels retire independently; move on once both are done.
                awvalid_d = awvalid_q && !M_AXI_AWREADY;
                wvalid_d  = wvalid_q && !M_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = StWrResp;
                    bready_d = 1'b1;
                end
            end
            StWrResp: begin
                if (M_AXI_BVALID && bready_q) begin
                    state_d     = StIdle;
                    bready_d    = 1'b0;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_rdata_d = '0;
                end
            end
            StRdReq: begin
                if (M_AXI_ARREADY && arvalid_q) begin
                    state_d   = StRdResp;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            StRdResp: begin
                if (M_AXI_RVALID && rready_q) begin
                    state_d     = StIdle;
                    rready_d    = 1'b0;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_rdata_d = M_AXI_RDATA;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

`ifdef AXI_MASTER_TIMEOUT_EN
    // The flag is registered, so matching one count early makes it rise exactly
    // TIMEOUT_CYCLES cycles after acceptance.
    localparam logic [15:0] TimeoutHit = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic        hit;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q != StIdle && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        hit       = (state_d != StIdle) && (cnt_d == TimeoutHit);
        timeout_d = accept ? hit : (timeout_q || hit);
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master; the watchdog test runs when AXI_MASTER_TIMEOUT_EN is set.
module tb_axi4_lite_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
`ifdef AXI_MASTER_TIMEOUT_EN
    logic        timeout;
`endif

    int checks = 0;
    int errors = 0;
    int rsp_count = 0;
    int rsp_base;

    always #5 clk = ~clk;

    always @(posedge clk) if (rsp_valid === 1'b1) rsp_count <= rsp_count + 1;

`ifdef AXI_MASTER_TIMEOUT_EN
    axi4_lite_master #(.TIMEOUT_CYCLES(8)) dut (
`else
    axi4_lite_master dut (
`endif
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_write    (rsp_write),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
`ifdef AXI_MASTER_TIMEOUT_EN
        .timeout      (timeout),
`endif
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BRESP  (bresp),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Every step observes outputs and drives inputs at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;

        // Reset state and release
        tick(); tick();
        chk1("rst_cmd_ready", cmd_ready, 1'b0);
        chk1("rst_awvalid", awvalid, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1;
        chk1("rel_cmd_ready_pre_edge", cmd_ready, 1'b0);
        tick();
        chk1("rel_cmd_ready", cmd_ready, 1'b1);

        // Write 0x10 <- DEADBEEF, slave ready one cycle after valid (cycle N)
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        tick(); // N+1
        chk1("wr_awvalid_n1", awvalid, 1'b1);
        chk1("wr_wvalid_n1", wvalid, 1'b1);
        chk32("wr_awaddr", awaddr, 32'h10);
        chk32("wr_wdata", wdata, 32'hDEADBEEF);
        chk32("wr_wstrb", 32'(wstrb), 32'hF);
        chk1("wr_cmd_ready_busy", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        tick(); // N+2
        chk1("wr_awvalid_n2", awvalid, 1'b1);
        chk1("wr_bready_n2", bready, 1'b0);
        awready = 1'b1; wready = 1'b1;
        tick(); // N+3
        chk1("wr_awvalid_n3", awvalid, 1'b0);
        chk1("wr_wvalid_n3", wvalid, 1'b0);
        chk1("wr_bready_n3", bready, 1'b1);
        chk1("wr_rsp_valid_n3", rsp_valid, 1'b0);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        tick(); // N+4
        chk1("wr_rsp_valid", rsp_valid, 1'b1);
        chk1("wr_rsp_write", rsp_write, 1'b1);
        chk32("wr_rsp_resp", 32'(rsp_resp), 32'h0);
        chk32("wr_rsp_rdata", rsp_rdata, 32'h0);
        chk1("wr_bready_n4", bready, 1'b0);
        chk1("wr_cmd_ready_n4", cmd_ready, 1'b1);
        bvalid = 1'b0;

        // Read back 0x10; a stray BVALID and a busy command must both be ignored
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        tick(); // M+1
        chk1("rd_arvalid", arvalid, 1'b1);
        chk32("rd_araddr", araddr, 32'h10);
        chk1("rd_cmd_ready_busy", cmd_ready, 1'b0);
        issue(1'b1, 32'h99, 32'h1111_2222, 4'hF);
        bvalid = 1'b1; arready = 1'b1;
        tick(); // M+2
        chk1("rd_arvalid_drop", arvalid, 1'b0);
        chk1("rd_rready", rready, 1'b1);
        chk1("rd_bready_stray", bready, 1'b0);
        chk1("rd_busy_no_aw", awvalid, 1'b0);
        chk1("rd_busy_cmd_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b0; bvalid = 1'b0; arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
        tick(); // M+3
        chk1("rd_rsp_valid", rsp_valid, 1'b1);
        chk1("rd_rsp_write", rsp_write, 1'b0);
        chk32("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        chk32("rd_rsp_resp", 32'(rsp_resp), 32'h0);
        chk1("rd_rready_drop", rready, 1'b0);
        rvalid = 1'b0; rdata = 32'h0;
        tick(); // M+4
        chk1("rd_rsp_pulse_end", rsp_valid, 1'b0);
        chk32("rd_rsp_rdata_hold", rsp_rdata, 32'hDEADBEEF);
        chk1("rd_busy_cmd_dropped", awvalid, 1'b0);

        // Split handshake: WREADY three cycles after AWREADY (cycle S)
        rsp_base = rsp_count;
        issue(1'b1, 32'h20, 32'h1234_5678, 4'h3);
        tick(); // S+1
        chk1("sp_awvalid", awvalid, 1'b1);
        chk1("sp_wvalid", wvalid, 1'b1);
        cmd_valid = 1'b0; awready = 1'b1;
        tick(); // S+2
        chk1("sp_awvalid_drop", awvalid, 1'b0);
        chk1("sp_wvalid_held2", wvalid, 1'b1);
        chk1("sp_bready_early", bready, 1'b0);
        awready = 1'b0;
        tick(); // S+3
        chk1("sp_wvalid_held3", wvalid, 1'b1);
        chk32("sp_wdata_stable", wdata, 32'h1234_5678);
        chk32("sp_wstrb_stable", 32'(wstrb), 32'h3);
        tick(); // S+4
        chk1("sp_wvalid_held4", wvalid, 1'b1);
        wready = 1'b1;
        tick(); // S+5
        chk1("sp_wvalid_drop", wvalid, 1'b0);
        chk1("sp_bready", bready, 1'b1);
        wready = 1'b0; bvalid = 1'b1; bresp = 2'b01;
        tick(); // S+6
        chk1("sp_rsp_valid", rsp_valid, 1'b1);
        chk32("sp_rsp_resp", 32'(rsp_resp), 32'h1);
        chk32("sp_rsp_rdata_zero", rsp_rdata, 32'h0);
        bvalid = 1'b0; bresp = 2'b00;
        tick(); // S+7
        chk1("sp_rsp_pulse_end", rsp_valid, 1'b0);
        chk32("sp_rsp_count", 32'(rsp_count - rsp_base), 32'd1);

        // SLVERR read response, reported without retry (cycle E)
        issue(1'b0, 32'h30, 32'h0, 4'h0);
        tick(); // E+1
        cmd_valid = 1'b0; arready = 1'b1;
        tick(); // E+2
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0BAD_0BAD; rresp = 2'b10;
        tick(); // E+3
        chk1("err_rsp_valid", rsp_valid, 1'b1);
        chk32("err_rsp_resp", 32'(rsp_resp), 32'h2);
        chk32("err_rsp_rdata", rsp_rdata, 32'h0BAD_0BAD);
        chk1("err_cmd_ready", cmd_ready, 1'b1);
        rvalid = 1'b0; rresp = 2'b00;
        tick(); // E+4
        chk1("err_no_retry", arvalid, 1'b0);

        // Reset while in WR_RESP (cycle W)
        issue(1'b1, 32'h40, 32'h0000_0055, 4'hF);
        tick(); // W+1
        cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
        tick(); // W+2
        chk1("rs_in_wr_resp", bready, 1'b1);
        awready = 1'b0; wready = 1'b0;
        rsp_base = rsp_count;
        #2 rst_n = 1'b0;
        bvalid = 1'b1;
        #1;
        chk1("rs_async_bready", bready, 1'b0);
        chk1("rs_async_awvalid", awvalid, 1'b0);
        chk1("rs_async_wvalid", wvalid, 1'b0);
        chk1("rs_async_arvalid", arvalid, 1'b0);
        chk1("rs_async_rready", rready, 1'b0);
        chk1("rs_async_cmd_ready", cmd_ready, 1'b0);
        chk32("rs_async_awaddr", awaddr, 32'h0);
        chk32("rs_async_rsp_resp", 32'(rsp_resp), 32'h0);
        tick(); tick();
        rst_n = 1'b1; bvalid = 1'b0;
        chk1("rs_rel_pre_edge", cmd_ready, 1'b0);
        tick();
        chk1("rs_rel_cmd_ready", cmd_ready, 1'b1);
        chk32("rs_no_rsp", 32'(rsp_count - rsp_base), 32'd0);

`ifdef AXI_MASTER_TIMEOUT_EN
        // Watchdog with TIMEOUT_CYCLES=8, BVALID delayed to cycle T+20
        issue(1'b1, 32'h50, 32'hCAFE_F00D, 4'hF);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) begin
                cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
            end
            if (k == 2) begin
                awready = 1'b0; wready = 1'b0;
            end
            chk1($sformatf("to_low_t%0d", k), timeout, 1'b0);
        end
        tick(); // T+8
        chk1("to_high_t8", timeout, 1'b1);
        for (int k = 9; k <= 20; k++) begin
            tick();
            if (k == 20) bvalid = 1'b1;
        end
        chk1("to_bready_held", bready, 1'b1);
        tick(); // T+21
        chk1("to_rsp_valid", rsp_valid, 1'b1);
        chk1("to_sticky", timeout, 1'b1);
        bvalid = 1'b0;
        issue(1'b0, 32'h60, 32'h0, 4'h0);
        tick(); // T+22
        chk1("to_cleared", timeout, 1'b0);
        chk1("to_next_arvalid", arvalid, 1'b1);
        cmd_valid = 1'b0;
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
